// File: rtl/mprj_io_pkg.sv
// Shared types and sizing helpers for the GPIO pad configuration loader.
package mprj_io_pkg;

  localparam int PAD_CFG_W = 13;

  typedef logic [PAD_CFG_W-1:0] pad_cfg_t;

  localparam pad_cfg_t DEFAULT_CFG = 13'h0403;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD_HI,
    ST_LOAD_LO
  } xfer_state_e;

  function automatic int chain1_len(input int area1_pads);
    return area1_pads;
  endfunction

  function automatic int chain2_len(input int area1_pads, input int total_pads);
    return total_pads - area1_pads;
  endfunction

  function automatic int chain_max_len(input int area1_pads, input int total_pads);
    int l1;
    int l2;
    l1 = chain1_len(area1_pads);
    l2 = chain2_len(area1_pads, total_pads);
    return (l1 > l2) ? l1 : l2;
  endfunction

  function automatic int slot_count(input int area1_pads, input int total_pads, input int cfg_bits);
    return chain_max_len(area1_pads, total_pads) * cfg_bits;
  endfunction

endpackage

// File: rtl/mprj_io_cfg_shifter.sv
// One chain's shift register: captures the chain's words (leading-zero padded
// to the longest chain) and presents the next serial bit, MSB first.
module mprj_io_cfg_shifter #(
  parameter int LX       = 19,
  parameter int LMAX     = 19,
  parameter int CFG_BITS = 13
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic [LX*CFG_BITS-1:0] words_i,
  output logic                   next_bit_o
);

  localparam int NB   = LMAX * CFG_BITS;
  localparam int LEAD = (LMAX - LX) * CFG_BITS;

  logic [NB-1:0] snap;
  logic [NB-1:0] sr_q;
  logic [NB-1:0] sr_d;

  // words_i slot k is the k-th word to leave the chain.
  always_comb begin
    snap = '0;
    for (int k = 0; k < LX; k++) begin
      snap[NB-1-LEAD-k*CFG_BITS -: CFG_BITS] = words_i[k*CFG_BITS +: CFG_BITS];
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = snap;
    end else if (advance_i) begin
      sr_d = {sr_q[NB-2:0], 1'b0};
    end
  end

  assign next_bit_o = sr_d[NB-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Per-pad configuration store plus the serial engine that shifts it into the
// two pad-area control chains.
module mprj_io_cfg_loader
  import mprj_io_pkg::*;
#(
  parameter int                  AREA1PADS   = 19,
  parameter int                  TOTAL_PADS  = 38,
  parameter int                  CFG_BITS    = 13,
  parameter int                  CLK_DIV     = 1,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = mprj_io_pkg::DEFAULT_CFG,
  parameter int                  ADDR_W      = $clog2(TOTAL_PADS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_1,
  output logic                serial_data_2
);

  localparam int L1    = chain1_len(AREA1PADS);
  localparam int L2    = chain2_len(AREA1PADS, TOTAL_PADS);
  localparam int LMAX  = chain_max_len(AREA1PADS, TOTAL_PADS);
  localparam int NB    = slot_count(AREA1PADS, TOTAL_PADS, CFG_BITS);
  localparam int BIT_W = $clog2(NB + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [CFG_BITS-1:0] mem_q [TOTAL_PADS];
  logic [CFG_BITS-1:0] mem_d [TOTAL_PADS];

  xfer_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic busy_q, busy_d, done_q, done_d;
  logic sclk_q, sclk_d, sload_q, sload_d;
  logic sd1_q, sd1_d, sd2_q, sd2_d;
  logic snap_load, shift_adv, div_last, bit_last, shifting;
  logic next_bit_1, next_bit_2;

  logic [L1*CFG_BITS-1:0] chain1_words;
  logic [L2*CFG_BITS-1:0] chain2_words;

  // Chain 1 leaves from its highest pad down; chain 2 from its lowest pad up.
  for (genvar k = 0; k < L1; k++) begin : g_chain1
    assign chain1_words[k*CFG_BITS +: CFG_BITS] = mem_q[L1-1-k];
  end
  for (genvar k = 0; k < L2; k++) begin : g_chain2
    assign chain2_words[k*CFG_BITS +: CFG_BITS] = mem_q[AREA1PADS+k];
  end

  assign cfg_rdata = (int'(cfg_addr) < TOTAL_PADS) ? mem_q[cfg_addr] : '0;

  // A write coinciding with an accepted start is dropped so the snapshot is exact.
  always_comb begin
    mem_d = mem_q;
    if (cfg_we && !busy_q && !xfer_start && (int'(cfg_addr) < TOTAL_PADS)) begin
      mem_d[cfg_addr] = cfg_wdata;
    end
  end

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(NB - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
    shift_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_start) begin
          snap_load = 1'b1;
          state_d   = ST_SHIFT_LO;
          div_d     = '0;
          bit_d     = '0;
        end
      end
      ST_SHIFT_LO: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d = '0;
          if (bit_last) begin
            state_d = ST_LOAD_HI;
          end else begin
            shift_adv = 1'b1;
            bit_d     = bit_q + BIT_W'(1);
            state_d   = ST_SHIFT_LO;
          end
        end
      end
      ST_LOAD_HI: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered images of the next state, so they change on the edge.
  assign shifting = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI);
  assign busy_d   = (state_d != ST_IDLE);
  assign sclk_d   = (state_d == ST_SHIFT_HI);
  assign sload_d  = (state_d == ST_LOAD_HI);
  assign sd1_d    = shifting & next_bit_1;
  assign sd2_d    = shifting & next_bit_2;

  mprj_io_cfg_shifter #(.LX(L1), .LMAX(LMAX), .CFG_BITS(CFG_BITS)) u_chain1 (
    .clock(clock), .reset(reset), .load_i(snap_load), .advance_i(shift_adv),
    .words_i(chain1_words), .next_bit_o(next_bit_1)
  );

  mprj_io_cfg_shifter #(.LX(L2), .LMAX(LMAX), .CFG_BITS(CFG_BITS)) u_chain2 (
    .clock(clock), .reset(reset), .load_i(snap_load), .advance_i(shift_adv),
    .words_i(chain2_words), .next_bit_o(next_bit_2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TOTAL_PADS; i++) mem_q[i] <= DEFAULT_CFG;
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sload_q <= 1'b0;
      sd1_q   <= 1'b0;
      sd2_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sload_q <= sload_d;
      sd1_q   <= sd1_d;
      sd2_q   <= sd2_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = sload_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Bench for mprj_io_cfg_loader: three instances (default, CLK_DIV=3, 3/8-pad ring).
module tb_mprj_io_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  we_v, start_v;
  logic [5:0]  a_addr, b_addr;
  logic [2:0]  c_addr;
  logic [12:0] wdata;
  logic [12:0] a_rdata, b_rdata, c_rdata;
  logic [2:0]  busy_v, done_v, sclk_v, sload_v, d1_v, d2_v;

  mprj_io_cfg_loader u_a (
    .clock(clk), .reset(rst), .cfg_we(we_v[0]), .cfg_addr(a_addr), .cfg_wdata(wdata),
    .cfg_rdata(a_rdata), .xfer_start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .serial_clock(sclk_v[0]), .serial_load(sload_v[0]),
    .serial_data_1(d1_v[0]), .serial_data_2(d2_v[0])
  );

  mprj_io_cfg_loader #(.CLK_DIV(3)) u_b (
    .clock(clk), .reset(rst), .cfg_we(we_v[1]), .cfg_addr(b_addr), .cfg_wdata(wdata),
    .cfg_rdata(b_rdata), .xfer_start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .serial_clock(sclk_v[1]), .serial_load(sload_v[1]),
    .serial_data_1(d1_v[1]), .serial_data_2(d2_v[1])
  );

  mprj_io_cfg_loader #(.AREA1PADS(3), .TOTAL_PADS(8)) u_c (
    .clock(clk), .reset(rst), .cfg_we(we_v[2]), .cfg_addr(c_addr), .cfg_wdata(wdata),
    .cfg_rdata(c_rdata), .xfer_start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .serial_clock(sclk_v[2]), .serial_load(sload_v[2]),
    .serial_data_1(d1_v[2]), .serial_data_2(d2_v[2])
  );

  localparam int A1_V   [3] = '{19, 19, 3};
  localparam int TOT_V  [3] = '{38, 38, 8};
  localparam int NB_V   [3] = '{247, 247, 65};
  localparam int BUSY_V [3] = '{496, 1488, 132};
  localparam int DIV_V  [3] = '{1, 3, 1};

  int tests = 0;
  int fails = 0;

  logic [12:0] mdl [3][38];

  // ---------------- monitor (negedge sampling) ----------------
  int clr_req  [3] = '{0, 0, 0};
  int clr_seen [3] = '{0, 0, 0};
  int busy_cnt [3], done_cnt [3], viol [3], cap_n [3];
  int hi_min [3], hi_max [3], lo_min [3], lo_max [3], ld_last [3];
  int hi_run [3], lo_run [3], ld_run [3];
  bit cap1 [3][512];
  bit cap2 [3][512];
  logic [2:0] sclk_prev = '0, sload_prev = '0, d1_hold = '0, d2_hold = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr_req[i] != clr_seen[i]) begin
        clr_seen[i] = clr_req[i];
        busy_cnt[i] = 0; done_cnt[i] = 0; viol[i] = 0; cap_n[i] = 0;
        hi_min[i] = 1 << 30; hi_max[i] = 0; lo_min[i] = 1 << 30; lo_max[i] = 0;
        ld_last[i] = 0; hi_run[i] = 0; lo_run[i] = 0; ld_run[i] = 0;
      end
      if (busy_v[i]) busy_cnt[i]++;
      if (done_v[i]) done_cnt[i]++;
      if (done_v[i] && busy_v[i]) viol[i]++;
      if (sclk_v[i] && sload_v[i]) viol[i]++;
      if ((d1_v[i] || d2_v[i]) && (sload_v[i] || !busy_v[i])) viol[i]++;
      if (sclk_v[i]) begin
        if (!sclk_prev[i]) begin
          if (lo_run[i] < lo_min[i]) lo_min[i] = lo_run[i];
          if (lo_run[i] > lo_max[i]) lo_max[i] = lo_run[i];
          lo_run[i] = 0;
          if (cap_n[i] < 512) begin
            cap1[i][cap_n[i]] = d1_v[i];
            cap2[i][cap_n[i]] = d2_v[i];
          end
          cap_n[i]++;
          d1_hold[i] = d1_v[i];
          d2_hold[i] = d2_v[i];
        end else if (d1_v[i] != d1_hold[i] || d2_v[i] != d2_hold[i]) begin
          viol[i]++;
        end
        hi_run[i]++;
      end else begin
        if (sclk_prev[i]) begin
          if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
          if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
          hi_run[i] = 0;
        end
        if (busy_v[i] && !sload_v[i]) lo_run[i]++;
      end
      if (!busy_v[i]) lo_run[i] = 0;
      if (sload_v[i]) ld_run[i]++;
      else if (sload_prev[i]) begin
        ld_last[i] = ld_run[i];
        ld_run[i] = 0;
      end
      sclk_prev[i]  = sclk_v[i];
      sload_prev[i] = sload_v[i];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_bit(input int i, input int ch, input int s);
    int a1, l2, lmax, lx, lead, k, b, pad;
    a1   = A1_V[i];
    l2   = TOT_V[i] - a1;
    lmax = (a1 > l2) ? a1 : l2;
    lx   = (ch == 1) ? a1 : l2;
    lead = (lmax - lx) * 13;
    if (s < lead) return 1'b0;
    k   = (s - lead) / 13;
    b   = 12 - ((s - lead) % 13);
    pad = (ch == 1) ? (a1 - 1 - k) : (a1 + k);
    return mdl[i][pad][b];
  endfunction

  task automatic start_xfer(input int i);
    clr_req[i]++;
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    we_v[i]    = 1'b0;
    check($sformatf("busy_after_start_%0d", i), busy_v[i], 1);
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done_v[i] && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("done_within_budget_%0d", i), done_v[i], 1);
    repeat (3) tick();
  endtask

  task automatic check_xfer(input int i, input string tag);
    int bad = 0;
    for (int s = 0; s < NB_V[i]; s++) begin
      if (cap1[i][s] != exp_bit(i, 1, s)) bad++;
      if (cap2[i][s] != exp_bit(i, 2, s)) bad++;
    end
    check({tag, "_bit_count"}, cap_n[i], NB_V[i]);
    check({tag, "_stream_errs"}, bad, 0);
    check({tag, "_busy_cycles"}, busy_cnt[i], BUSY_V[i]);
    check({tag, "_done_pulses"}, done_cnt[i], 1);
    check({tag, "_protocol_viol"}, viol[i], 0);
    check({tag, "_sclk_hi_min"}, hi_min[i], DIV_V[i]);
    check({tag, "_sclk_hi_max"}, hi_max[i], DIV_V[i]);
    check({tag, "_sclk_lo_min"}, lo_min[i], DIV_V[i]);
    check({tag, "_sclk_lo_max"}, lo_max[i], DIV_V[i]);
    check({tag, "_load_hi"}, ld_last[i], DIV_V[i]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 38; p++) mdl[i][p] = 13'h0403;
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [12:0] wdata;
    logic [12:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] last1, last2;
    int n;
    vecs[0]  = '{1'b0, 6'd0,  13'h0000, 13'h0403};
    vecs[1]  = '{1'b0, 6'd37, 13'h0000, 13'h0403};
    vecs[2]  = '{1'b0, 6'd38, 13'h0000, 13'h0000};
    vecs[3]  = '{1'b0, 6'd63, 13'h0000, 13'h0000};
    vecs[4]  = '{1'b1, 6'd0,  13'h1FFF, 13'h0403};
    vecs[5]  = '{1'b0, 6'd0,  13'h0000, 13'h1FFF};
    vecs[6]  = '{1'b1, 6'd37, 13'h0001, 13'h0403};
    vecs[7]  = '{1'b0, 6'd37, 13'h0000, 13'h0001};
    vecs[8]  = '{1'b1, 6'd38, 13'h1234, 13'h0000};
    vecs[9]  = '{1'b0, 6'd38, 13'h0000, 13'h0000};
    vecs[10] = '{1'b0, 6'd18, 13'h0000, 13'h0403};
    vecs[11] = '{1'b0, 6'd19, 13'h0000, 13'h0403};

    reset_model();
    rst = 1'b1; we_v = '0; start_v = '0; a_addr = '0; b_addr = '0; c_addr = '0; wdata = '0;

    // ---- reset defaults ----
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outs_%0d", i),
            {busy_v[i], done_v[i], sclk_v[i], sload_v[i], d1_v[i], d2_v[i]}, 0);
    rst = 1'b0;
    tick();
    for (int p = 0; p < 38; p++) begin
      a_addr = 6'(p);
      #1;
      check($sformatf("default_rd_%0d", p), a_rdata, 13'h0403);
    end
    c_addr = 3'd7;
    #1;
    check("c_default_rd_7", c_rdata, 13'h0403);
    tick();

    // ---- store read/write vectors ----
    for (int k = 0; k < 12; k++) begin
      we_v[0] = vecs[k].we;
      a_addr  = vecs[k].addr;
      wdata   = vecs[k].wdata;
      #1;
      check($sformatf("rd_vec%0d", k), a_rdata, vecs[k].exp_rd);
      tick();
    end
    we_v[0] = 1'b0;
    mdl[0][0]  = 13'h1FFF;
    mdl[0][37] = 13'h0001;

    // ---- full transfer, CLK_DIV=1 ----
    start_xfer(0);
    wait_done(0, 2000);
    check_xfer(0, "a_xfer");
    for (int b = 0; b < 13; b++) begin
      last1[12-b] = cap1[0][234+b];
      last2[12-b] = cap2[0][234+b];
    end
    check("a_chain1_last_word", last1, 13'h1FFF);
    check("a_chain2_last_word", last2, 13'h0001);

    // ---- CLK_DIV=3, default store ----
    start_xfer(1);
    wait_done(1, 3000);
    check_xfer(1, "b_xfer");

    // ---- asymmetric ring, all words 13'h1555 ----
    for (int p = 0; p < 8; p++) begin
      we_v[2] = 1'b1; c_addr = 3'(p); wdata = 13'h1555;
      tick();
      mdl[2][p] = 13'h1555;
    end
    we_v[2] = 1'b0;
    c_addr = 3'd5;
    #1;
    check("c_rd_after_write", c_rdata, 13'h1555);
    start_xfer(2);
    wait_done(2, 500);
    check_xfer(2, "c_xfer");
    n = 0;
    for (int s = 0; s < 26; s++) if (cap1[2][s]) n++;
    check("c_chain1_lead_zero_ones", n, 0);
    check("c_chain1_first_data_bit", cap1[2][26], 1);
    check("c_chain2_first_bit", cap2[2][0], 1);

    // ---- write with start, write + restart while busy ----
    we_v[0] = 1'b1; a_addr = 6'd5; wdata = 13'h0AAA;
    start_xfer(0);
    repeat (50) tick();
    we_v[0] = 1'b1; a_addr = 6'd6; wdata = 13'h0BBB; start_v[0] = 1'b1;
    tick();
    we_v[0] = 1'b0; start_v[0] = 1'b0;
    wait_done(0, 2000);
    repeat (10) tick();
    check_xfer(0, "snap_xfer");
    a_addr = 6'd5;
    #1;
    check("snap_rd_pad5", a_rdata, 13'h0403);
    a_addr = 6'd6;
    #1;
    check("busy_rd_pad6", a_rdata, 13'h0403);
    tick();

    // ---- reset in the middle of a transfer ----
    start_xfer(0);
    n = 0;
    while (cap_n[0] < 100 && n < 1000) begin
      tick();
      n++;
    end
    check("abort_reached_bit100", (cap_n[0] >= 100), 1);
    rst = 1'b1;
    #1;
    check("abort_outs_zero",
          {busy_v[0], done_v[0], sclk_v[0], sload_v[0], d1_v[0], d2_v[0]}, 0);
    tick();
    tick();
    rst = 1'b0;
    reset_model();
    repeat (3) tick();
    check("abort_no_done", done_cnt[0], 0);
    a_addr = 6'd0;
    #1;
    check("abort_store_pad0", a_rdata, 13'h0403);
    a_addr = 6'd37;
    #1;
    check("abort_store_pad37", a_rdata, 13'h0403);
    tick();
    start_xfer(0);
    wait_done(0, 2000);
    check_xfer(0, "post_reset_xfer");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
